// File: rtl/estufa_controle.sv
// Greenhouse climate controller.
// Turns the two temperature threshold bits into heater/cooler commands.
// A started heater or cooler run is held for a minimum on-time.
// A debounced sensor inconsistency latches a fault, and the fault stays
// latched until it is acknowledged.
module estufa_controle #(
    parameter int MIN_ON       = 4,
    parameter int FAULT_CYCLES = 2
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       t1,
    input  logic       t2,
    input  logic       ack,
    output logic       aquecedor,
    output logic       resfriador,
    output logic       falha,
    output logic [1:0] estado
);

    localparam int TW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    localparam int IW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
    localparam logic [TW-1:0] TEMPO_MAX  = TW'(MIN_ON - 1);
    localparam logic [IW-1:0] INCONS_MAX = IW'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {
        DESLIGADO  = 2'b00,
        AQUECENDO  = 2'b01,
        RESFRIANDO = 2'b10,
        FALHA      = 2'b11
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] tempo;
    logic [IW-1:0] incons;

    logic frio;
    logic ok;
    logic quente;
    logic inc;
    logic trip;
    logic dwell_met;

    // Classify the current sensor sample.
    // "Hot but not warm" (t1=0, t2=1) is physically impossible.
    assign frio   = ~t1 & ~t2;
    assign ok     =  t1 & ~t2;
    assign quente =  t1 &  t2;
    assign inc    = ~t1 &  t2;

    assign trip      = inc && (incons == INCONS_MAX);
    assign dwell_met = (tempo == TEMPO_MAX);
    assign estado    = state;

    // Next-state decision.
    // A fault trip wins over everything else, including the dwell rule.
    always_comb begin
        next_state = state;
        if (trip && state != FALHA) begin
            next_state = FALHA;
        end else begin
            case (state)
                DESLIGADO: begin
                    if (frio)
                        next_state = AQUECENDO;
                    else if (quente)
                        next_state = RESFRIANDO;
                end
                AQUECENDO: begin
                    if (dwell_met && (ok || quente))
                        next_state = DESLIGADO;
                end
                RESFRIANDO: begin
                    if (dwell_met && (ok || frio))
                        next_state = DESLIGADO;
                end
                FALHA: begin
                    if (ack && !inc)
                        next_state = DESLIGADO;
                end
                default: next_state = DESLIGADO;
            endcase
        end
    end

    // State register with registered Moore outputs and the dwell and inconsistency counters.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state      <= DESLIGADO;
            aquecedor  <= 1'b0;
            resfriador <= 1'b0;
            falha      <= 1'b0;
            tempo      <= '0;
            incons     <= '0;
        end else begin
            state      <= next_state;
            aquecedor  <= (next_state == AQUECENDO);
            resfriador <= (next_state == RESFRIANDO);
            falha      <= (next_state == FALHA);

            if (next_state != state)
                tempo <= '0;
            else if ((state == AQUECENDO || state == RESFRIANDO) && !dwell_met)
                tempo <= tempo + 1'b1;

            if (state == FALHA || !inc)
                incons <= '0;
            else if (incons != INCONS_MAX)
                incons <= incons + 1'b1;
        end
    end

endmodule

// File: tb/tb_estufa_controle.sv
// Self-checking bench for estufa_controle.
// Directed scenarios are checked against hand-derived expected values.
// A randomized run is checked against a mode/run-length reference model.
module tb_estufa_controle;

    localparam int MIN_ON       = 4;
    localparam int FAULT_CYCLES = 2;

    // Packed observation {estado, aquecedor, resfriador, falha}
    localparam logic [4:0] OFF  = 5'b00000;
    localparam logic [4:0] HEAT = 5'b01100;
    localparam logic [4:0] COOL = 5'b10010;
    localparam logic [4:0] FLT  = 5'b11001;

    // Stimulus word {reset, t1, t2, ack}
    localparam logic [3:0] RST  = 4'b1100;
    localparam logic [3:0] FRIO = 4'b0000;
    localparam logic [3:0] OKS  = 4'b0100;
    localparam logic [3:0] QUE  = 4'b0110;
    localparam logic [3:0] INC  = 4'b0010;
    localparam logic [3:0] ACK  = 4'b0001;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       t1;
    logic       t2;
    logic       ack;
    logic       aquecedor;
    logic       resfriador;
    logic       falha;
    logic [1:0] estado;
    logic [4:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    // m_mode: 0 off, 1 heating, 2 cooling, 3 fault.
    // m_dwell: edges spent in the current mode.
    // m_run: consecutive INCONS samples seen outside the fault mode.
    int m_mode  = 0;
    int m_dwell = 0;
    int m_run   = 0;

    estufa_controle #(.MIN_ON(MIN_ON), .FAULT_CYCLES(FAULT_CYCLES)) dut (
        .clk_2(clk_2),
        .reset(reset),
        .t1(t1),
        .t2(t2),
        .ack(ack),
        .aquecedor(aquecedor),
        .resfriador(resfriador),
        .falha(falha),
        .estado(estado)
    );

    assign obs = {estado, aquecedor, resfriador, falha};

    // Free-running clock.
    always #5 clk_2 = ~clk_2;

    // Advance the reference model by one clock edge.
    task automatic model_update(input logic [3:0] s);
        logic r, a, b, k, frio_c, ok_c, que_c, inc_c, trip, met;
        int   nm;
        {r, a, b, k} = s;
        if (r) begin
            m_mode  = 0;
            m_dwell = 0;
            m_run   = 0;
        end else begin
            frio_c = !a && !b;
            ok_c   =  a && !b;
            que_c  =  a &&  b;
            inc_c  = !a &&  b;
            trip   = inc_c && m_mode != 3 && (m_run + 1 >= FAULT_CYCLES);
            met    = m_dwell >= MIN_ON - 1;
            nm     = m_mode;
            if (trip) nm = 3;
            else if (m_mode == 0 && frio_c) nm = 1;
            else if (m_mode == 0 && que_c) nm = 2;
            else if (m_mode == 1 && met && (ok_c || que_c)) nm = 0;
            else if (m_mode == 2 && met && (ok_c || frio_c)) nm = 0;
            else if (m_mode == 3 && k && !inc_c) nm = 0;
            m_run   = (inc_c && m_mode != 3) ? m_run + 1 : 0;
            m_dwell = (nm != m_mode) ? 0 : m_dwell + 1;
            m_mode  = nm;
        end
    endtask

    // Expected observation for the current model mode.
    function automatic logic [4:0] model_obs();
        logic [1:0] code;
        code = 2'(m_mode);
        return {code, m_mode == 1, m_mode == 2, m_mode == 3};
    endfunction

    // Apply one stimulus word across a rising edge.
    // The DUT is left settled at edge + 1 for sampling.
    task automatic applyStimulus(input logic [3:0] s);
        {reset, t1, t2, ack} = s;
        @(posedge clk_2);
        #1;
        model_update(s);
    endtask

    task automatic test_reset();
        logic [3:0] stim [3];
        logic [4:0] want [3];
        stim = '{4'b1111, 4'b1011, 4'b1001};
        want = '{OFF, OFF, OFF};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL reset[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_heater_dwell();
        logic [3:0] stim [7];
        logic [4:0] want [7];
        stim = '{RST, FRIO, OKS, OKS, OKS, OKS, OKS};
        want = '{OFF, HEAT, HEAT, HEAT, HEAT, OFF, OFF};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL heater_dwell[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_cooler_changeover();
        logic [3:0] stim [13];
        logic [4:0] want [13];
        stim = '{RST, QUE, QUE, QUE, QUE, QUE, QUE, QUE, QUE, QUE, QUE, FRIO, FRIO};
        want = '{OFF, COOL, COOL, COOL, COOL, COOL, COOL, COOL, COOL, COOL, COOL, OFF, HEAT};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL cooler_changeover[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_fault_threshold();
        logic [3:0] stim [6];
        logic [4:0] want [6];
        stim = '{RST, INC, OKS, INC, INC, OKS};
        want = '{OFF, OFF, OFF, OFF, FLT, FLT};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL fault_threshold[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_fault_during_dwell();
        logic [3:0] stim [6];
        logic [4:0] want [6];
        stim = '{RST, FRIO, OKS, INC, INC, INC};
        want = '{OFF, HEAT, HEAT, HEAT, FLT, FLT};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL fault_during_dwell[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_ack();
        logic [3:0] stim [11];
        logic [4:0] want [11];
        stim = '{RST, INC, INC, INC | ACK, OKS, OKS | ACK, INC, INC,
                 FRIO | ACK, FRIO | ACK, QUE | ACK};
        want = '{OFF, OFF, FLT, FLT, FLT, OFF, OFF, FLT, OFF, HEAT, HEAT};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL ack[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] stim [11];
        logic [4:0] want [11];
        stim = '{RST, INC, INC, 4'b1010, INC, OKS, QUE, INC, 4'b1010, INC, OKS};
        want = '{OFF, OFF, FLT, OFF, OFF, OFF, COOL, COOL, OFF, OFF, OFF};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(stim[i]);
            vectors++;
            if (obs !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL reset_mid[%0d]: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] cls;
        logic       r, k;
        logic [4:0] want;
        cls = 2'b00;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            k = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0)
                cls = 2'($urandom_range(0, 3));
            applyStimulus({r, cls, k});
            want = model_obs();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] in=%b: got %b expected %b", i, {r, cls, k}, obs, want);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        t1    = 1'b0;
        t2    = 1'b0;
        ack   = 1'b0;
        test_reset();
        test_heater_dwell();
        test_cooler_changeover();
        test_fault_threshold();
        test_fault_during_dwell();
        test_ack();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/estufa_controle.md
# estufa_controle

Sequential climate controller for the greenhouse: consumes the two threshold-sensor bits (t1 = temperature ≥ 15 °C, t2 = temperature ≥ 20 °C) and drives heater, cooler and fault indication. It sits directly downstream of the combinational sensor decode in `top`, which wires it to the switches, LEDs and segment display. It adds what plain decode cannot provide: a minimum actuator on-time, debounced fault detection and a latched fault that needs acknowledgement.

## Interface
- MIN_ON, 4: minimum number of cycles heater/cooler stays on once started (≥1)
- FAULT_CYCLES, 2: consecutive inconsistent samples that declare a fault (≥1)
- clk_2  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- t1  input  1  1 = temperature ≥ 15 °C
- t2  input  1  1 = temperature ≥ 20 °C
- ack  input  1  fault acknowledge; sampled only in FALHA
- aquecedor  output  1  heater on
- resfriador  output  1  cooler on
- falha  output  1  sensor fault latched
- estado  output  2  current state code, for the LCD display

## Operation
- Input class per sample:
  - FRIO: t1=0, t2=0
  - OK: t1=1, t2=0
  - QUENTE: t1=1, t2=1
  - INCONS: t1=0, t2=1
- States (estado code):
  - DESLIGADO = 00
  - AQUECENDO = 01
  - RESFRIANDO = 10
  - FALHA = 11
- Moore outputs:
  - aquecedor = (estado == 01)
  - resfriador = (estado == 10)
  - falha = (estado == 11)
  - At most one output is ever high.
- Dwell counter `tempo`:
  - Width $clog2(MIN_ON) (1 minimum).
  - Cleared to 0 on every state change.
  - Increments each cycle in AQUECENDO or RESFRIANDO, saturating at MIN_ON-1.
  - "Dwell met" means tempo == MIN_ON-1.
- Inconsistency counter `incons`:
  - Increments on INCONS samples, saturating at FAULT_CYCLES-1.
  - Cleared on any non-INCONS sample and while in FALHA.
  - "Fault trip" means the sample is INCONS and incons == FAULT_CYCLES-1.
- Transitions, highest priority first:
  - reset → DESLIGADO.
  - Fault trip in any state other than FALHA → FALHA. This overrides the dwell rule.
  - DESLIGADO:
    - FRIO → AQUECENDO
    - QUENTE → RESFRIANDO
    - OK or INCONS → stay
  - AQUECENDO:
    - Dwell met and class OK or QUENTE → DESLIGADO
    - Otherwise stay
  - RESFRIANDO:
    - Dwell met and class OK or FRIO → DESLIGADO
    - Otherwise stay
  - FALHA:
    - ack=1 and class ≠ INCONS → DESLIGADO
    - Otherwise stay
- There is no direct AQUECENDO↔RESFRIANDO transition. A changeover always passes through one DESLIGADO cycle.
- ack is ignored in every state except FALHA. ack held high does not re-trigger anything.
- INCONS samples below the trip threshold hold the current state and do not advance any exit.

## Timing
- Reset values: estado=00, aquecedor=0, resfriador=0, falha=0, tempo=0, incons=0.
- Reset asserted mid-operation, including in FALHA, takes effect at the next edge and overrides all other inputs.
- Latency: an input sampled at edge N is reflected on the outputs after edge N (one cycle). All outputs come from registers, so there is no combinational input→output path.
- Minimum on-time: a heater/cooler run is high for at least MIN_ON consecutive cycles, unless a fault trip or reset occurs.
- Exit timing: if the exit condition is present when the dwell is met, the output drops after exactly MIN_ON cycles high.
- Fault timing: falha rises after the FAULT_CYCLES-th consecutive INCONS edge.
- Fault clear: FALHA → DESLIGADO takes one cycle after a valid ack.
  - A FRIO or QUENTE class then starts the actuator one cycle later.
  - So the earliest actuator restart is 2 cycles after ack.

## Test plan
- Dwell, heater (MIN_ON=4, FAULT_CYCLES=2): reset, then t1=0,t2=0 for 1 edge, then t1=1,t2=0 held → aquecedor=1 for exactly 4 cycles, then estado=00 and all outputs 0.
- Cooler and changeover: t1=1,t2=1 held for 10 cycles → resfriador=1 throughout, estado=10. Then t1=0,t2=0 → one cycle estado=00, then aquecedor=1.
- Fault threshold: in DESLIGADO, one INCONS edge followed by OK → no fault, estado=00. Two consecutive INCONS edges → falha=1, estado=11, aquecedor=resfriador=0.
- Fault during dwell: in AQUECENDO at tempo=1, apply two INCONS edges → FALHA, aquecedor=0 even though dwell was not met.
- Acknowledge:
  - In FALHA, ack=1 with INCONS → stays at 11.
  - ack=1 with OK → estado=00, falha=0 next cycle.
  - ack=1 with FRIO → estado=00, then 01 on the following cycle.
- Reset mid-operation: reset=1 for one edge while in FALHA, and separately while in RESFRIANDO → all outputs 0, estado=00 after that edge. Counters cleared: a subsequent single INCONS sample does not trip the fault.
